gates_mux_bist: RTL

//  Built-in self-test engine for the 2-input mux-built gate block (outputs and/or/nand/nor/xor/xnor).

---
 rtl/gates_bist_pkg.sv | 34 +++
 rtl/gates_golden.sv | 12 +
 rtl/gates_mux_bist.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gates_bist_pkg.sv
// Shared definitions for the mux-built gate block self-test: state encoding,
// output bit positions and the golden truth table.
package gates_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bit positions inside the 6-bit output vector {and,or,nand,nor,xor,xnor}
    localparam int IDX_AND  = 5;
    localparam int IDX_OR   = 4;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_XOR  = 1;
    localparam int IDX_XNOR = 0;

    // Expected gate outputs for one input vector
    function automatic logic [5:0] golden6(input logic a, input logic b);
        logic [5:0] g;
        g           = '0;
        g[IDX_AND]  = a & b;
        g[IDX_OR]   = a | b;
        g[IDX_NAND] = ~(a & b);
        g[IDX_NOR]  = ~(a | b);
        g[IDX_XOR]  = a ^ b;
        g[IDX_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/gates_golden.sv
// Combinational reference for the gate block: a,b -> expected six outputs.
module gates_golden
    import gates_bist_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [5:0] expected
);

    assign expected = golden6(a, b);

endmodule

// File: rtl/gates_mux_bist.sv
// Self-test engine for the mux-built gate block. Sweeps {a,b} through
// 00,01,10,11 for PASSES sweeps, waits SETTLE_CYCLES clocks per vector,
// compares the six observed outputs with the golden table and records a
// saturating error count plus the first failing vector and mask.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start after reset
//   ST_DRIVE  | present vector counter on a,b; load settle down-counter
//   ST_SETTLE | count settle clocks down to 1
//   ST_CHECK  | compare outputs, log errors, advance vector/pass counters
//   ST_DONE   | result valid; start launches a new run
module gates_mux_bist
    import gates_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             yand,
    input  logic             yor,
    input  logic             ynand,
    input  logic             ynor,
    input  logic             yxor,
    input  logic             yxnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic [5:0]       fail_mask
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

    state_t     state, state_n;
    logic [1:0] vec_cnt;
    logic [7:0] pass_cnt;
    logic [3:0] settle_cnt;
    logic [5:0] observed;
    logic [5:0] expected;
    logic [5:0] mismatch;

    assign observed = {yand, yor, ynand, ynor, yxor, yxnor};

    gates_golden u_golden (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    // Case-inequality so an X or Z on any observed output flags that bit
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < 6; i++) begin
            mismatch[i] = (observed[i] !== expected[i]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state and status outputs
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_n = ST_DRIVE;
            ST_DRIVE:  begin
                busy    = 1'b1;
                state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt <= 4'd1) state_n = ST_CHECK;
            end
            ST_CHECK:  begin
                busy = 1'b1;
                if (vec_cnt == 2'd3 && pass_cnt == LAST_PASS) state_n = ST_DONE;
                else                                          state_n = ST_DRIVE;
            end
            ST_DONE:   begin
                done = 1'b1;
                if (start) state_n = ST_DRIVE;
            end
            default:   state_n = ST_IDLE;
        endcase
        pass = done && (err_count == '0);
    end

    // Stimulus, counters and error capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a          <= 1'b0;
            b          <= 1'b0;
            vec_cnt    <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_cnt   <= '0;
                        pass_cnt  <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        fail_mask <= '0;
                    end
                end
                ST_DRIVE: begin
                    {a, b}     <= vec_cnt;
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: settle_cnt <= settle_cnt - 4'd1;
                ST_CHECK: begin
                    if (|mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (err_count == '0) begin
                            fail_vec  <= {a, b};
                            fail_mask <= mismatch;
                        end
                    end
                    vec_cnt <= vec_cnt + 2'd1;
                    if (vec_cnt == 2'd3) pass_cnt <= pass_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
